// File: rtl/csr_pkg.sv
// Shared CSR codec definitions: FSM states and default
// geometry used by both the encoder and decoder stages.
package csr_pkg;

  localparam int IMAGE_SIZE         = 28;
  localparam int WORD_LENGTH        = 8;
  localparam int COL_LENGTH         = 8;
  localparam int DOUBLE_WORD_LENGTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/csr_entry_slot.sv
// One-deep CSR entry buffer: turns (col,row) into a raster
// position and drops entries that are out of range or order.
module csr_entry_slot
  import csr_pkg::*;
#(
  parameter int col_length         = COL_LENGTH,
  parameter int word_length        = WORD_LENGTH,
  parameter int double_word_length = DOUBLE_WORD_LENGTH,
  parameter int image_size         = IMAGE_SIZE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          load,
  input  logic                          take,
  input  logic [word_length-1:0]        value,
  input  logic [col_length-1:0]         col,
  input  logic [col_length-1:0]         row,
  input  logic [double_word_length-1:0] pos,
  output logic                          buf_valid,
  output logic [double_word_length-1:0] buf_pos,
  output logic [word_length-1:0]        buf_value,
  output logic                          drop
);

  localparam logic [col_length-1:0] LIM =
    col_length'(image_size);
  localparam logic [double_word_length-1:0] IMG =
    double_word_length'(image_size);

  logic [double_word_length-1:0] epos;
  logic                          bad;

  assign epos = double_word_length'(row) * IMG
              + double_word_length'(col);

  // Anything behind the raster cursor can no longer be emitted.
  assign bad  = (col >= LIM) || (row >= LIM) || (epos < pos);
  assign drop = load && bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_pos   <= '0;
      buf_value <= '0;
    end else if (clear) begin
      buf_valid <= 1'b0;
      buf_pos   <= '0;
      buf_value <= '0;
    end else if (load && !bad) begin
      buf_valid <= 1'b1;
      buf_pos   <= epos;
      buf_value <= value;
    end else if (take) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/csr_decoder.sv
// CSR to dense raster expander: replays buffered nonzero
// entries into a zero-filled image_size x image_size stream.
module csr_decoder
  import csr_pkg::*;
#(
  parameter int col_length         = COL_LENGTH,
  parameter int word_length        = WORD_LENGTH,
  parameter int double_word_length = DOUBLE_WORD_LENGTH,
  parameter int image_size         = IMAGE_SIZE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [double_word_length-1:0] nnz,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [word_length-1:0]        in_value,
  input  logic [col_length-1:0]         in_col,
  input  logic [col_length-1:0]         in_row,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [word_length-1:0]        data_out,
  output logic                          out_last,
  output logic                          done,
  output logic                          err,
  output logic                          busy
);

  localparam int DW = double_word_length;
  localparam logic [DW-1:0] LAST =
    DW'(image_size * image_size - 1);
  localparam logic [DW-1:0] ONE = DW'(1);

  state_t                 state;
  logic [DW-1:0]          pos;
  logic [DW-1:0]          remaining;
  logic                   err_q;
  logic                   streaming;
  logic                   accept;
  logic                   fire;
  logic                   hit;
  logic                   take;
  logic                   slot_clear;
  logic                   buf_valid;
  logic                   drop;
  logic [DW-1:0]          buf_pos;
  logic [word_length-1:0] buf_value;

  assign streaming  = (state == STREAM);
  assign in_ready   = streaming && !buf_valid
                   && (remaining != '0);
  // With entries still owed, wait for the next one so
  // zeros are never emitted past a pending nonzero.
  assign out_valid  = streaming
                   && (buf_valid || remaining == '0);
  assign hit        = buf_valid && (buf_pos == pos);
  assign data_out   = (out_valid && hit) ? buf_value : '0;
  assign out_last   = out_valid && (pos == LAST);
  assign fire       = out_valid && out_ready;
  assign take       = fire && hit;
  assign accept     = in_valid && in_ready;
  assign slot_clear = (state == IDLE) && start;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign err        = err_q;

  csr_entry_slot #(
    .col_length        (col_length),
    .word_length       (word_length),
    .double_word_length(double_word_length),
    .image_size        (image_size)
  ) u_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (slot_clear),
    .load     (accept),
    .take     (take),
    .value    (in_value),
    .col      (in_col),
    .row      (in_row),
    .pos      (pos),
    .buf_valid(buf_valid),
    .buf_pos  (buf_pos),
    .buf_value(buf_value),
    .drop     (drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pos       <= '0;
      remaining <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= STREAM;
            remaining <= nnz;
            pos       <= '0;
            err_q     <= 1'b0;
          end
        end
        STREAM: begin
          if (accept) remaining <= remaining - ONE;
          if (drop) err_q <= 1'b1;
          if (fire) begin
            pos <= pos + ONE;
            if (out_last) begin
              state <= DONE;
              if (remaining != '0) err_q <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
